// File: rtl/apb_mon_pkg.sv
// Shared types for the APB protocol monitor: phase states, violation codes
// and the helper that maps a code onto its sticky-flag bit.
package apb_mon_pkg;

    localparam int N_ERR = 5;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESYNC
    } mon_state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_SETUP   = 3'd1,
        ERR_ACCESS  = 3'd2,
        ERR_STABLE  = 3'd3,
        ERR_TIMEOUT = 3'd4,
        ERR_PENABLE = 3'd5
    } err_code_t;

    // Code k owns sticky bit k-1; ERR_NONE maps to no bit at all.
    function automatic logic [N_ERR-1:0] err_onehot(input err_code_t code);
        logic [N_ERR-1:0] mask;
        mask = '0;
        if (code != ERR_NONE) begin
            mask = N_ERR'(1) << (code - 3'd1);
        end
        return mask;
    endfunction

endpackage

// File: rtl/apb_sat_counter.sv
// Saturating event counter; a clear in the same cycle as an event loads 1.
module apb_sat_counter #(
    parameter int W = 16
) (
    input  logic         pclk,
    input  logic         preset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge pclk) begin
        if (preset) begin
            count <= '0;
        end else if (clr) begin
            count <= W'(inc);
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB3 slave-port checker: tracks each transfer's phase, reports
// protocol violations and counts completed reads, writes and slave errors.
module apb_protocol_monitor
    import apb_mon_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic              clr,
    output logic              err_pulse,
    output logic [2:0]        err_code,
    output logic [ADDR_W-1:0] err_addr,
    output logic [N_ERR-1:0]  err_sticky,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  slverr_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1) + 1;

    mon_state_t        state, nxt_state;
    err_code_t         ev_err;
    logic [ADDR_W-1:0] ev_addr;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_write;
    logic [DATA_W-1:0] cap_data;
    logic [WAIT_W-1:0] wait_cnt, nxt_wait, wait_inc;
    logic              capture, done_wr, done_rd, done_slverr;
    logic              prdata_unused;

    assign prdata_unused = ^prdata;

    always_comb begin
        nxt_state   = state;
        ev_err      = ERR_NONE;
        ev_addr     = cap_addr;
        capture     = 1'b0;
        nxt_wait    = wait_cnt;
        wait_inc    = wait_cnt + WAIT_W'(1);
        done_wr     = 1'b0;
        done_rd     = 1'b0;
        done_slverr = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    capture   = 1'b1;
                    nxt_wait  = '0;
                    nxt_state = SETUP;
                end else if (psel && penable) begin
                    ev_err    = ERR_SETUP;
                    ev_addr   = paddr;
                    nxt_state = RESYNC;
                end else if (!psel && penable) begin
                    ev_err  = ERR_PENABLE;
                    ev_addr = paddr;
                end
            end
            // The branch order below is the violation priority within a transfer.
            SETUP, ACCESS: begin
                if (!psel || !penable) begin
                    ev_err    = ERR_ACCESS;
                    nxt_state = psel ? RESYNC : IDLE;
                end else if ((paddr != cap_addr) || (pwrite != cap_write) ||
                             (pwrite && (pwdata != cap_data))) begin
                    ev_err    = ERR_STABLE;
                    nxt_state = RESYNC;
                end else if (pready) begin
                    done_wr     = cap_write;
                    done_rd     = !cap_write;
                    done_slverr = pslverr;
                    nxt_state   = IDLE;
                end else if (wait_inc > WAIT_W'(TIMEOUT)) begin
                    ev_err    = ERR_TIMEOUT;
                    nxt_state = RESYNC;
                end else begin
                    nxt_wait  = wait_inc;
                    nxt_state = ACCESS;
                end
            end
            RESYNC: begin
                if (!psel) begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = RESYNC;
        endcase
    end

    // Coming out of reset the monitor resyncs, so a half-seen transfer is ignored.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state      <= RESYNC;
            cap_addr   <= '0;
            cap_write  <= 1'b0;
            cap_data   <= '0;
            wait_cnt   <= '0;
            err_pulse  <= 1'b0;
            err_code   <= 3'd0;
            err_addr   <= '0;
            err_sticky <= '0;
        end else begin
            state     <= nxt_state;
            wait_cnt  <= nxt_wait;
            err_pulse <= (ev_err != ERR_NONE);
            if (capture) begin
                cap_addr  <= paddr;
                cap_write <= pwrite;
                cap_data  <= pwdata;
            end
            if (ev_err != ERR_NONE) begin
                err_code <= ev_err;
                err_addr <= ev_addr;
            end
            err_sticky <= (clr ? '0 : err_sticky) | err_onehot(ev_err);
        end
    end

    apb_sat_counter #(.W(CNT_W)) u_wr_cnt (
        .pclk(pclk), .preset(preset), .inc(done_wr), .clr(clr), .count(wr_cnt)
    );

    apb_sat_counter #(.W(CNT_W)) u_rd_cnt (
        .pclk(pclk), .preset(preset), .inc(done_rd), .clr(clr), .count(rd_cnt)
    );

    apb_sat_counter #(.W(CNT_W)) u_slverr_cnt (
        .pclk(pclk), .preset(preset), .inc(done_slverr), .clr(clr), .count(slverr_cnt)
    );

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Two monitors (default and TIMEOUT=4/CNT_W=2) watch one shared APB bus and
// are compared every cycle against a transfer-level reference model.
module tb_apb_protocol_monitor;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic [7:0]  paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0, prdata = '0;
    logic        pready = 1'b0, pslverr = 1'b0, clr = 1'b0;

    logic        pulse_a, pulse_b;
    logic [2:0]  code_a, code_b;
    logic [7:0]  addr_a, addr_b;
    logic [4:0]  sticky_a, sticky_b;
    logic [15:0] wr_a, rd_a, se_a;
    logic [1:0]  wr_b, rd_b, se_b;

    int errors = 0;
    int checks = 0;

    always #5 pclk = ~pclk;

    apb_protocol_monitor u_dut_a (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .clr(clr), .err_pulse(pulse_a), .err_code(code_a),
        .err_addr(addr_a), .err_sticky(sticky_a), .wr_cnt(wr_a), .rd_cnt(rd_a),
        .slverr_cnt(se_a)
    );

    apb_protocol_monitor #(.TIMEOUT(4), .CNT_W(2)) u_dut_b (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .clr(clr), .err_pulse(pulse_b), .err_code(code_b),
        .err_addr(addr_b), .err_sticky(sticky_b), .wr_cnt(wr_b), .rd_cnt(rd_b),
        .slverr_cnt(se_b)
    );

    // Reference model state, index 0 = instance a, 1 = instance b.
    int          m_tmo[2] = '{16, 4};
    int          m_max[2] = '{65535, 3};
    bit          m_lost[2], m_act[2], m_capw[2];
    int          m_capa[2], m_waits[2];
    logic [31:0] m_capd[2];
    int          e_pulse[2], e_code[2], e_addr[2], e_sticky[2], e_wr[2], e_rd[2], e_se[2];

    function automatic int sat(input int cur, input bit inc, input bit c, input int max);
        if (c) return inc ? 1 : 0;
        if (inc && cur < max) return cur + 1;
        return cur;
    endfunction

    function automatic void modelStep(input int k);
        int code, addr;
        bit wrInc, rdInc, seInc;
        code = 0; addr = 0; wrInc = 0; rdInc = 0; seInc = 0;
        if (preset) begin
            m_lost[k] = 1; m_act[k] = 0; m_waits[k] = 0;
            e_pulse[k] = 0; e_code[k] = 0; e_addr[k] = 0; e_sticky[k] = 0;
            e_wr[k] = 0; e_rd[k] = 0; e_se[k] = 0;
            return;
        end
        if (m_lost[k]) begin
            if (!psel) m_lost[k] = 0;
        end else if (!m_act[k]) begin
            if (psel && !penable) begin
                m_act[k] = 1; m_capa[k] = paddr; m_capw[k] = pwrite;
                m_capd[k] = pwdata; m_waits[k] = 0;
            end else if (psel && penable) begin
                code = 1; addr = paddr; m_lost[k] = 1;
            end else if (!psel && penable) begin
                code = 5; addr = paddr;
            end
        end else begin
            addr = m_capa[k];
            if (!psel || !penable) begin
                code = 2; m_act[k] = 0; m_lost[k] = psel;
            end else if (paddr != m_capa[k] || pwrite != m_capw[k] ||
                         (pwrite && pwdata != m_capd[k])) begin
                code = 3; m_act[k] = 0; m_lost[k] = 1;
            end else if (pready) begin
                wrInc = m_capw[k]; rdInc = !m_capw[k]; seInc = pslverr; m_act[k] = 0;
            end else begin
                m_waits[k]++;
                if (m_waits[k] > m_tmo[k]) begin
                    code = 4; m_act[k] = 0; m_lost[k] = 1;
                end
            end
        end
        e_pulse[k] = (code != 0) ? 1 : 0;
        if (code != 0) begin
            e_code[k] = code;
            e_addr[k] = addr;
        end
        e_sticky[k] = (clr ? 0 : e_sticky[k]) | ((code != 0) ? (1 << (code - 1)) : 0);
        e_wr[k] = sat(e_wr[k], wrInc, clr, m_max[k]);
        e_rd[k] = sat(e_rd[k], rdInc, clr, m_max[k]);
        e_se[k] = sat(e_se[k], seInc, clr, m_max[k]);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic checkInst(input int k, input logic p, input logic [2:0] c,
                             input logic [7:0] a, input logic [4:0] s,
                             input logic [15:0] w, input logic [15:0] r, input logic [15:0] e);
        checkOutput($sformatf("i%0d.pulse", k), 32'(p), e_pulse[k]);
        checkOutput($sformatf("i%0d.code", k), 32'(c), e_code[k]);
        checkOutput($sformatf("i%0d.addr", k), 32'(a), e_addr[k]);
        checkOutput($sformatf("i%0d.sticky", k), 32'(s), e_sticky[k]);
        checkOutput($sformatf("i%0d.wr", k), 32'(w), e_wr[k]);
        checkOutput($sformatf("i%0d.rd", k), 32'(r), e_rd[k]);
        checkOutput($sformatf("i%0d.slverr", k), 32'(e), e_se[k]);
    endtask

    // Drive one bus cycle, advance the model at the edge, compare just after it.
    task automatic applyStimulus(input bit s, input bit e, input bit w, input logic [7:0] a,
                                 input logic [31:0] d, input bit rdy, input bit se, input bit c);
        psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
        pready = rdy; pslverr = se; clr = c; prdata = $urandom;
        @(posedge pclk);
        modelStep(0);
        modelStep(1);
        #1;
        checkInst(0, pulse_a, code_a, addr_a, sticky_a, wr_a, rd_a, se_a);
        checkInst(1, pulse_b, code_b, addr_b, sticky_b, 16'(wr_b), 16'(rd_b), 16'(se_b));
    endtask

    // fault: 0 none, 1 drop penable, 2 flip paddr, 3 drop psel, 4 change pwdata.
    task automatic doTransfer(input logic [7:0] a, input bit w, input logic [31:0] d,
                              input int waits, input bit se, input int fault,
                              input int faultAt, input bit clrEnd);
        applyStimulus(1, 0, w, a, d, 0, 0, 0);
        for (int i = 0; i <= waits; i++) begin
            bit s, e, last;
            logic [7:0] fa;
            logic [31:0] fd;
            s = 1; e = 1; fa = a; fd = d; last = (i == waits);
            if (fault != 0 && i == faultAt) begin
                case (fault)
                    1: e = 0;
                    2: fa = a ^ 8'h01;
                    3: s = 0;
                    default: fd = ~d;
                endcase
            end
            applyStimulus(s, e, w, fa, fd, last, last && se, last && clrEnd);
        end
    endtask

    task automatic idle(input bit c);
        applyStimulus(0, 0, 0, 8'h00, 32'h0, 0, 0, c);
    endtask

    initial begin
        $display("[TB] start");
        // Reset with a transfer apparently in flight; nothing must be flagged.
        preset = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 8'h55, 32'h0, 0, 0, 0);
        preset = 1'b0;
        applyStimulus(1, 1, 0, 8'h55, 32'h0, 0, 0, 0);
        idle(0);
        checkOutput("rst.pulse_a", 32'(pulse_a), 0);
        checkOutput("rst.wr_a", 32'(wr_a), 0);

        // Write with two wait states, back-to-back read with slave error.
        doTransfer(8'h3C, 1, 32'hDEADBEEF, 2, 0, 0, 0, 0);
        doTransfer(8'h10, 0, 32'h0, 0, 1, 0, 0, 0);
        idle(0);
        checkOutput("b2b.wr_a", 32'(wr_a), 1);
        checkOutput("b2b.rd_a", 32'(rd_a), 1);
        checkOutput("b2b.slverr_a", 32'(se_a), 1);

        // psel arrives with penable already high.
        applyStimulus(1, 1, 0, 8'h22, 32'h0, 0, 0, 0);
        checkOutput("setup.pulse", 32'(pulse_a), 1);
        checkOutput("setup.code", 32'(code_a), 1);
        checkOutput("setup.addr", 32'(addr_a), 32'h22);
        checkOutput("setup.sticky", 32'(sticky_a), 32'h01);
        idle(0);

        // Address moves during a wait state, then a clean transfer.
        doTransfer(8'h40, 1, 32'h12345678, 3, 0, 2, 1, 0);
        checkOutput("stable.code", 32'(code_a), 3);
        checkOutput("stable.addr", 32'(addr_a), 32'h40);
        idle(0);
        doTransfer(8'h44, 1, 32'hCAFE0001, 1, 0, 0, 0, 0);

        // Timeout on instance b (limit 4), then an exact 4-wait transfer.
        idle(1);
        doTransfer(8'h60, 0, 32'h0, 6, 0, 0, 0, 0);
        checkOutput("tmo.code_b", 32'(code_b), 4);
        idle(0);
        doTransfer(8'h64, 0, 32'h0, 4, 0, 0, 0, 0);
        checkOutput("tmo4.rd_b", 32'(rd_b), 1);
        idle(0);

        // Saturation of the 2-bit write counter and clear on the 5th completion.
        idle(1);
        for (int n = 1; n <= 5; n++) begin
            doTransfer(8'h70, 1, 32'h0, 0, 0, 0, 0, n == 5);
            if (n >= 3 && n <= 4) checkOutput("sat.wr_b", 32'(wr_b), 3);
        end
        checkOutput("clr.wr_b", 32'(wr_b), 1);
        checkOutput("clr.sticky_b", 32'(sticky_b), 0);

        // Randomised traffic with occasional faults, glitches and clears.
        for (int t = 0; t < 300; t++) begin
            int waits, fault;
            waits = $urandom_range(0, 6);
            fault = ($urandom_range(0, 7) < 6) ? 0 : $urandom_range(1, 4);
            doTransfer(8'($urandom), 1'($urandom), $urandom, waits, 1'($urandom),
                       fault, $urandom_range(0, waits), $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(0, $urandom_range(0, 7) == 0, 0, 8'($urandom), 32'h0,
                              0, 0, $urandom_range(0, 15) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
